// File: rtl/prog_loader_pkg.sv
// Shared state encoding and constants for the serial program loader.
package prog_loader_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    RUN  = 2'd3
  } state_t;
endpackage

// File: rtl/prog_ram.sv
// Instruction store: synchronous write, asynchronous read, no reset.
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);
  logic [BYTE_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_loader.sv
// Serial program loader: shifts a program bit-serially into prog_ram and serves it by PC.
// Define PROG_CHECKSUM_EN to treat the final loaded byte as an XOR checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              ld_valid,
  input  logic              ld_bit,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [BYTE_W-1:0] instruction,
  output logic              core_rst,
  output logic              loading,
  output logic [ADDR_W:0]   prog_len,
  output logic              load_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_LEN = (ADDR_W+1)'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [BYTE_W-1:0] shreg, byte_nxt, rdata;
  logic              hold, shift_en, byte_done, last_byte, start_load;
`ifdef PROG_CHECKSUM_EN
  logic [BYTE_W-1:0] xacc;
  logic              chk_ok;

  // XOR over data plus checksum byte is zero exactly when the checksum matches.
  assign chk_ok = (xacc == '0) && (prog_len != '0);
`else
  assign load_err = 1'b0;
`endif

  assign shift_en  = (state == LOAD) && ld_valid;
  assign byte_done = shift_en && (bit_cnt == 3'd7);
  assign last_byte = byte_done && (prog_len == LAST_LEN);
  assign byte_nxt  = {shreg[BYTE_W-2:0], ld_bit};

  // hold blocks an immediate reload when load_en is still high after an auto-stop on full.
  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_en && !hold) begin
          state_nxt  = LOAD;
          start_load = 1'b1;
        end else if (!load_err) begin
          state_nxt = RUN;
        end
      end
      LOAD: begin
        if (last_byte || !load_en) begin
`ifdef PROG_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = RUN;
`endif
        end
      end
      CHK: begin
`ifdef PROG_CHECKSUM_EN
        state_nxt = chk_ok ? RUN : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      RUN: begin
        if (load_en && !hold) begin
          state_nxt  = LOAD;
          start_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      wr_ptr   <= '0;
      shreg    <= '0;
      prog_len <= '0;
      hold     <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      xacc     <= '0;
      load_err <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (!load_en)       hold <= 1'b0;
      else if (last_byte) hold <= 1'b1;

      if (start_load) begin
        bit_cnt  <= '0;
        wr_ptr   <= '0;
        shreg    <= '0;
        prog_len <= '0;
`ifdef PROG_CHECKSUM_EN
        xacc     <= '0;
        load_err <= 1'b0;
`endif
      end else if (shift_en) begin
        shreg   <= byte_nxt;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          wr_ptr   <= wr_ptr + ADDR_W'(1);
          prog_len <= prog_len + (ADDR_W+1)'(1);
`ifdef PROG_CHECKSUM_EN
          xacc     <= xacc ^ byte_nxt;
`endif
        end
      end

`ifdef PROG_CHECKSUM_EN
      // The checksum byte is stored but excluded from the served program.
      if (state == CHK) begin
        if (chk_ok) prog_len <= prog_len - (ADDR_W+1)'(1);
        else        load_err <= 1'b1;
      end
`endif
    end
  end

  prog_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (byte_done),
    .waddr (wr_ptr),
    .wdata (byte_nxt),
    .raddr (pc_addr),
    .rdata (rdata)
  );

  assign core_rst    = rst | (state != RUN);
  assign loading     = (state == LOAD) || (state == CHK);
  assign instruction = ((state == RUN) && ({1'b0, pc_addr} < prog_len)) ? rdata : NOP_INSTR;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: transaction-level program model, random and directed loads.
module tb_prog_loader;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef PROG_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct {
    string           name;
    logic [7:0]      instr;
    logic            core_rst;
    logic            loading;
    logic [ADDR_W:0] plen;
    logic            err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, load_en, ld_valid, ld_bit;
  logic [ADDR_W-1:0] pc_addr;
  logic [7:0]        instruction;
  logic              core_rst, loading, load_err;
  logic [ADDR_W:0]   prog_len;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .ld_valid    (ld_valid),
    .ld_bit      (ld_bit),
    .pc_addr     (pc_addr),
    .instruction (instruction),
    .core_rst    (core_rst),
    .loading     (loading),
    .prog_len    (prog_len),
    .load_err    (load_err)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  logic probe_v = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: the program as a list of stored bytes plus run/load/error status.
  logic [7:0] ref_mem [DEPTH];
  int         ref_len, got;
  bit         ref_run, ref_load, ref_err, ended, full;

  logic [7:0] rnd_bytes[$];
  logic [7:0] xs;
  int         n, part;
  bit         drop;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (probe_v) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL probe: no expectation queued");
      end else begin
        mon_e = exp_q.pop_front();
        cmp({mon_e.name, ".instr"},    32'(instruction), 32'(mon_e.instr));
        cmp({mon_e.name, ".core_rst"}, 32'(core_rst),    32'(mon_e.core_rst));
        cmp({mon_e.name, ".loading"},  32'(loading),     32'(mon_e.loading));
        cmp({mon_e.name, ".prog_len"}, 32'(prog_len),    32'(mon_e.plen));
        cmp({mon_e.name, ".load_err"}, 32'(load_err),    32'(mon_e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input string nm, input logic [ADDR_W-1:0] pc);
    exp_t e;
    e.name     = nm;
    e.instr    = (ref_run && (int'(pc) < ref_len)) ? ref_mem[pc] : 8'h00;
    e.core_rst = !ref_run;
    e.loading  = ref_load;
    e.plen     = (ADDR_W+1)'(ref_len);
    e.err      = ref_err;
    return e;
  endfunction

  task automatic probe(input string nm, input logic [ADDR_W-1:0] pc);
    pc_addr = pc;
    exp_q.push_back(mk(nm, pc));
    probe_v = 1'b1;
    tick();
    probe_v = 1'b0;
  endtask

  function automatic void finalize();
    logic [7:0] x;
    ended    = 1'b1;
    ref_load = 1'b0;
    if (!CSUM) begin
      ref_len = got;
      ref_run = 1'b1;
    end else begin
      x = 8'h00;
      for (int i = 0; i < got; i++) x ^= ref_mem[i];
      if (got > 0 && x == 8'h00) begin
        ref_len = got - 1;
        ref_run = 1'b1;
      end else begin
        ref_len = got;
        ref_err = 1'b1;
        ref_run = 1'b0;
      end
    end
  endfunction

  task automatic start_load();
    load_en = 1'b1;
    tick();
    ref_load = 1'b1; ref_run = 1'b0; ref_err = 1'b0; ref_len = 0;
    got = 0; ended = 1'b0; full = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ld_valid = 1'b1;
    ld_bit   = b;
    tick();
    ld_valid = 1'b0;
    repeat ($urandom_range(0, 1)) begin
      ld_bit = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop_last);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && drop_last) load_en = 1'b0;
      send_bit(b[i]);
    end
    if (!full) begin
      ref_mem[got] = b;
      got++;
      ref_len = got;
      if (got == DEPTH) begin
        full = 1'b1;
        finalize();
      end
    end
    if (drop_last && !ended) finalize();
  endtask

  task automatic finish_load();
    load_en = 1'b0;
    if (!ended) finalize();
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_en = 1'b0; ld_valid = 1'b0; ld_bit = 1'b0; pc_addr = '0;
    ref_run = 1'b0; ref_load = 1'b0; ref_err = 1'b0; ref_len = 0;
    got = 0; ended = 1'b1; full = 1'b0;

    // Reset held for two cycles, then an empty program runs.
    tick(); tick();
    probe("reset_a", 4'd0);
    probe("reset_b", 4'd5);
    rst = 1'b0;
    tick();
    ref_run = 1'b1;
    probe("empty_run", 4'd2);

    // Three-byte program.
    start_load();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    probe("mid_load", 4'd0);
    send_byte(8'h0F, 1'b0);
    finish_load();
    for (int pc = 0; pc < 4; pc++) probe($sformatf("three_pc%0d", pc), 4'(pc));

    // Full memory with load_en held; the 17th byte must be ignored.
    start_load();
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b0);
    send_byte(8'h5A ^ ref_mem[DEPTH-1], 1'b0);
    probe("full_hold", 4'd15);
    finish_load();
    for (int pc = 0; pc < DEPTH; pc++) probe($sformatf("full_pc%0d", pc), 4'(pc));

    // Two bytes plus a discarded partial byte.
    start_load();
    send_byte(8'hC1, 1'b0);
    send_byte(8'h9E, 1'b0);
    repeat (5) send_bit(1'b1);
    finish_load();
    for (int pc = 0; pc < 4; pc++) probe($sformatf("partial_pc%0d", pc), 4'(pc));

    // Reload from the running state.
    start_load();
    probe("reload_core_rst", 4'd0);
    send_byte(8'h7E, 1'b0);
    finish_load();
    probe("reload_pc0", 4'd0);
    probe("reload_pc1", 4'd1);

    // load_en falls together with the 8th bit: that byte is kept.
    start_load();
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC6, 1'b1);
    finish_load();
    for (int pc = 0; pc < 3; pc++) probe($sformatf("drop8_pc%0d", pc), 4'(pc));

    // Checksum patterns: matching, then mismatching trailer.
    start_load();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h00, 1'b0);
    finish_load();
    for (int pc = 0; pc < 5; pc++) probe($sformatf("csum_ok_pc%0d", pc), 4'(pc));
    start_load();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h01, 1'b0);
    finish_load();
    for (int pc = 0; pc < 5; pc++) probe($sformatf("csum_bad_pc%0d", pc), 4'(pc));

    // Randomized programs: length, content, partial tail, drop timing.
    for (int it = 0; it < 40; it++) begin
      rnd_bytes.delete();
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) rnd_bytes.push_back(8'($urandom));
      if (CSUM && n < DEPTH && $urandom_range(0, 1) == 1) begin
        xs = 8'h00;
        foreach (rnd_bytes[i]) xs ^= rnd_bytes[i];
        rnd_bytes.push_back(xs);
      end
      drop = ($urandom_range(0, 2) == 0);
      part = drop ? 0 : $urandom_range(0, 7);
      start_load();
      foreach (rnd_bytes[i]) send_byte(rnd_bytes[i], drop && (i == rnd_bytes.size() - 1));
      repeat (part) send_bit(1'($urandom));
      finish_load();
      for (int pc = 0; pc < DEPTH; pc++) probe($sformatf("rnd%0d_pc%0d", it, pc), 4'(pc));
    end

    repeat (4) tick();
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
